usb_protocol_ctrl: RTL and testbench

- Transaction sequencer for the USB endpoint. It consumes packet events from usb_rx and issues handshake and data packets to usb_tx.
- Tracks DATA0/DATA1 toggles for both directions.
- Arbitrates ownership of the shared data buffer between the RX and TX paths.
- Drives buffer clear and status pulses to the AHB-side interface.

---
 rtl/usb_protocol_ctrl_if.sv | 31 +++
 rtl/usb_protocol_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_usb_protocol_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_protocol_ctrl_if.sv
// Signal bundle between the USB transaction sequencer and its usb_rx, usb_tx
// and buffer/AHB-side peers.
interface usb_protocol_ctrl_if;
  logic [3:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       rx_error;
  logic       tx_done;
  logic       tx_error;
  logic [6:0] buffer_occupancy;
  logic       data_request;
  logic       tx_start;
  logic [3:0] tx_packet;
  logic       d_mode;
  logic       clear;
  logic       rx_done;
  logic       tx_complete;
  logic       proto_error;

  modport master (
    input  rx_packet, rx_data_ready, rx_transfer_active, rx_error,
    input  tx_done, tx_error, buffer_occupancy, data_request,
    output tx_start, tx_packet, d_mode, clear, rx_done, tx_complete, proto_error
  );

  modport slave (
    output rx_packet, rx_data_ready, rx_transfer_active, rx_error,
    output tx_done, tx_error, buffer_occupancy, data_request,
    input  tx_start, tx_packet, d_mode, clear, rx_done, tx_complete, proto_error
  );
endinterface

// File: rtl/usb_protocol_ctrl.sv
// USB endpoint transaction sequencer: reacts to decoded host packets, issues
// handshake/data PIDs, tracks DATA0/DATA1 toggles and owns the buffer direction.
module usb_protocol_ctrl #(
  parameter int TIMEOUT_CYCLES = 96,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  usb_protocol_ctrl_if.master bus
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_SEND_HS,
    S_SEND_DATA,
    S_WAIT_ACK
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic             rx_toggle_reg, rx_toggle_next;
  logic             tx_toggle_reg, tx_toggle_next;
  logic             tx_start_reg, tx_start_next;
  logic [3:0]       tx_packet_reg, tx_packet_next;
  logic             d_mode_reg, d_mode_next;
  logic             clear_reg, clear_next;
  logic             rx_done_reg, rx_done_next;
  logic             tx_complete_reg, tx_complete_next;
  logic             proto_error_reg, proto_error_next;

  logic rx_fault;
  logic rx_event;
  logic tx_fault;
  logic is_data_pid;
  logic data_is_new;
  logic in_ready;
  logic timed_out;
  logic waiting;

  // rx_error masks a coincident rx_data_ready; tx_error masks tx_done.
  assign rx_fault    = bus.rx_error;
  assign rx_event    = bus.rx_data_ready && !bus.rx_error;
  assign tx_fault    = bus.tx_error;
  assign is_data_pid = (bus.rx_packet == PID_DATA0) || (bus.rx_packet == PID_DATA1);
  assign data_is_new = (bus.rx_packet[3] == rx_toggle_reg);
  assign in_ready    = bus.data_request && (bus.buffer_occupancy != 7'd0);
  assign timed_out   = (timer_reg == TIMER_LAST);
  assign waiting     = (state_reg == S_WAIT_DATA) || (state_reg == S_WAIT_ACK);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg       <= S_IDLE;
      timer_reg       <= '0;
      rx_toggle_reg   <= 1'b0;
      tx_toggle_reg   <= 1'b0;
      tx_start_reg    <= 1'b0;
      tx_packet_reg   <= 4'b0000;
      d_mode_reg      <= 1'b0;
      clear_reg       <= 1'b0;
      rx_done_reg     <= 1'b0;
      tx_complete_reg <= 1'b0;
      proto_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      rx_toggle_reg   <= rx_toggle_next;
      tx_toggle_reg   <= tx_toggle_next;
      tx_start_reg    <= tx_start_next;
      tx_packet_reg   <= tx_packet_next;
      d_mode_reg      <= d_mode_next;
      clear_reg       <= clear_next;
      rx_done_reg     <= rx_done_next;
      tx_complete_reg <= tx_complete_next;
      proto_error_reg <= proto_error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (rx_event) begin
          if (bus.rx_packet == PID_OUT) begin
            state_next = S_WAIT_DATA;
          end else if (bus.rx_packet == PID_IN) begin
            state_next = in_ready ? S_SEND_DATA : S_SEND_HS;
          end
        end
      end
      S_WAIT_DATA: begin
        if (rx_fault) begin
          state_next = S_IDLE;
        end else if (rx_event) begin
          state_next = is_data_pid ? S_SEND_HS : S_IDLE;
        end else if (timed_out) begin
          state_next = S_IDLE;
        end
      end
      S_SEND_HS: begin
        if (tx_fault || bus.tx_done) state_next = S_IDLE;
      end
      S_SEND_DATA: begin
        if (tx_fault) begin
          state_next = S_IDLE;
        end else if (bus.tx_done) begin
          state_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (rx_fault || rx_event || timed_out) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_start_next    = 1'b0;
    tx_packet_next   = tx_packet_reg;
    clear_next       = 1'b0;
    rx_done_next     = 1'b0;
    tx_complete_next = 1'b0;
    proto_error_next = 1'b0;
    rx_toggle_next   = rx_toggle_reg;
    tx_toggle_next   = tx_toggle_reg;
    d_mode_next      = (state_next == S_SEND_DATA) || (state_next == S_WAIT_ACK);
    timer_next       = '0;

    case (state_reg)
      S_IDLE: begin
        if (rx_fault) begin
          clear_next = 1'b1;
        end else if (rx_event) begin
          if (bus.rx_packet == PID_IN) begin
            tx_start_next  = 1'b1;
            tx_packet_next = in_ready ? (tx_toggle_reg ? PID_DATA1 : PID_DATA0) : PID_NAK;
          end else if (bus.rx_packet != PID_OUT) begin
            proto_error_next = 1'b1;
          end
        end
      end
      S_WAIT_DATA: begin
        if (rx_fault) begin
          clear_next = 1'b1;
        end else if (rx_event) begin
          if (is_data_pid) begin
            tx_start_next  = 1'b1;
            tx_packet_next = PID_ACK;
            // A stale toggle is a host retransmission: ACK it but drop the payload.
            if (data_is_new) begin
              rx_toggle_next = !rx_toggle_reg;
              rx_done_next   = 1'b1;
            end else begin
              clear_next = 1'b1;
            end
          end else begin
            proto_error_next = 1'b1;
            clear_next       = 1'b1;
          end
        end else if (timed_out) begin
          proto_error_next = 1'b1;
        end
      end
      S_SEND_HS, S_SEND_DATA: begin
        if (tx_fault) proto_error_next = 1'b1;
      end
      S_WAIT_ACK: begin
        if (rx_event && !rx_fault && bus.rx_packet == PID_ACK) begin
          tx_toggle_next   = !tx_toggle_reg;
          clear_next       = 1'b1;
          tx_complete_next = 1'b1;
        end else if (rx_fault || rx_event || timed_out) begin
          proto_error_next = 1'b1;
        end
      end
      default: ;
    endcase

    // Timer restarts on every wait entry and only runs while the bus is quiet.
    if (waiting && state_next == state_reg) begin
      timer_next = timer_reg;
      if (!bus.rx_transfer_active && !timed_out) timer_next = timer_reg + CNT_W'(1);
    end
  end

  assign bus.tx_start    = tx_start_reg;
  assign bus.tx_packet   = tx_packet_reg;
  assign bus.d_mode      = d_mode_reg;
  assign bus.clear       = clear_reg;
  assign bus.rx_done     = rx_done_reg;
  assign bus.tx_complete = tx_complete_reg;
  assign bus.proto_error = proto_error_reg;

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// Self-checking bench for usb_protocol_ctrl: vector table, directed corner
// sequences and randomized transactions against a transaction-level model.
module tb_usb_protocol_ctrl;
  localparam logic [3:0] P_OUT   = 4'b0001;
  localparam logic [3:0] P_IN    = 4'b1001;
  localparam logic [3:0] P_ACK   = 4'b0010;
  localparam logic [3:0] P_NAK   = 4'b1010;
  localparam logic [3:0] P_D0    = 4'b0011;
  localparam logic [3:0] P_D1    = 4'b1011;
  localparam logic [3:0] P_SETUP = 4'b1101;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_protocol_ctrl_if bus();

  usb_protocol_ctrl #(.TIMEOUT_CYCLES(96), .CNT_W(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic m_rx_tog;
  logic m_tx_tog;
  int   at;

  // Outputs as {tx_start, tx_packet, d_mode, clear, rx_done, tx_complete, proto_error}.
  typedef struct packed {
    logic       rdy;
    logic       err;
    logic [3:0] pid;
    logic       dr;
    logic [6:0] occ;
    logic [1:0] rec;
    logic [9:0] want;
    logic [9:0] rec_want;
  } vec_t;
  vec_t vecs [10];
  logic [3:0] bad_pids [5];

  function automatic logic [9:0] E(input logic ts, input logic [3:0] pkt, input logic [4:0] flags);
    return {ts, pkt, flags};
  endfunction

  task automatic check(input string name, input logic [9:0] want, input logic pkt_care);
    logic [9:0] act;
    logic [9:0] w;
    act = {bus.tx_start, bus.tx_packet, bus.d_mode, bus.clear, bus.rx_done,
           bus.tx_complete, bus.proto_error};
    w = want;
    if (!pkt_care) begin
      act[8:5] = 4'd0;
      w[8:5]   = 4'd0;
    end
    n_checks++;
    if (act !== w) begin
      n_errors++;
      $display("FAIL %s: got ts|pkt|dm|clr|rd|tc|pe=%b_%b_%b expected %b_%b_%b",
               name, act[9], act[8:5], act[4:0], w[9], w[8:5], w[4:0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic idle_inputs();
    bus.rx_data_ready      = 1'b0;
    bus.rx_error           = 1'b0;
    bus.tx_done            = 1'b0;
    bus.tx_error           = 1'b0;
    bus.rx_transfer_active = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic send_pid(input logic [3:0] pid);
    bus.rx_packet     = pid;
    bus.rx_data_ready = 1'b1;
    tick();
  endtask

  task automatic pulse_tx_done();
    bus.tx_done = 1'b1;
    tick();
  endtask

  task automatic wait_pe(input int limit, input int act_cycles, output int hit);
    hit = -1;
    for (int i = 1; i <= limit; i++) begin
      bus.rx_transfer_active = (i <= act_cycles);
      tick();
      if (bus.proto_error === 1'b1) begin
        hit = i;
        break;
      end
    end
  endtask

  task automatic finish_tx(input logic [3:0] pkt, input logic dm);
    int gap;
    gap = $urandom_range(0, 3);
    for (int g = 0; g < gap; g++) begin
      tick();
      check("r_tx_hold", E(1'b0, pkt, {dm, 4'b0000}), 1'b1);
    end
    pulse_tx_done();
    check("r_tx_done", E(1'b0, 4'd0, {dm, 4'b0000}), 1'b0);
  endtask

  task automatic rand_txn(input int t);
    int         kind;
    int         gap;
    logic       b;
    logic       fresh;
    logic       ready;
    logic       dr;
    logic [6:0] occ;
    logic [3:0] pkt;
    kind = $urandom_range(0, 9);
    if (kind <= 3) begin
      send_pid(P_OUT);
      check("r_out_tok", E(1'b0, 4'd0, 5'b00000), 1'b0);
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        bus.rx_transfer_active = 1'($urandom_range(0, 1));
        tick();
        check("r_out_gap", E(1'b0, 4'd0, 5'b00000), 1'b0);
      end
      b = 1'($urandom_range(0, 1));
      fresh = (b == m_rx_tog);
      send_pid(b ? P_D1 : P_D0);
      check("r_out_data", E(1'b1, P_ACK, {1'b0, !fresh, fresh, 2'b00}), 1'b1);
      if (fresh) m_rx_tog = !m_rx_tog;
      finish_tx(P_ACK, 1'b0);
      $display("txn %0d OUT DATA%0d %s", t, b, fresh ? "new" : "duplicate");
    end else if (kind <= 7) begin
      dr    = 1'($urandom_range(0, 1));
      occ   = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 64));
      ready = dr && (occ != 7'd0);
      pkt   = ready ? (m_tx_tog ? P_D1 : P_D0) : P_NAK;
      bus.data_request     = dr;
      bus.buffer_occupancy = occ;
      send_pid(P_IN);
      check("r_in_tok", E(1'b1, pkt, {ready, 4'b0000}), 1'b1);
      finish_tx(pkt, ready);
      if (ready) begin
        gap = $urandom_range(0, 5);
        for (int g = 0; g < gap; g++) begin
          bus.rx_transfer_active = 1'($urandom_range(0, 1));
          tick();
          check("r_in_wait", E(1'b0, 4'd0, 5'b10000), 1'b0);
        end
        if ($urandom_range(0, 3) != 0) begin
          send_pid(P_ACK);
          check("r_in_ack", E(1'b0, 4'd0, 5'b01010), 1'b0);
          m_tx_tog = !m_tx_tog;
        end else begin
          send_pid(P_NAK);
          check("r_in_badresp", E(1'b0, 4'd0, 5'b00001), 1'b0);
        end
      end
      $display("txn %0d IN dr=%0d occ=%0d pid=%b", t, dr, occ, pkt);
    end else if (kind == 8) begin
      pkt = bad_pids[$urandom_range(0, 4)];
      send_pid(pkt);
      check("r_bad_tok", E(1'b0, 4'd0, 5'b00001), 1'b0);
      $display("txn %0d stray pid=%b", t, pkt);
    end else begin
      bus.rx_error      = 1'b1;
      bus.rx_data_ready = 1'($urandom_range(0, 1));
      bus.rx_packet     = 4'($urandom_range(0, 15));
      tick();
      check("r_rx_err", E(1'b0, 4'd0, 5'b01000), 1'b0);
      $display("txn %0d rx_error in idle", t);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bad_pids = '{P_ACK, P_NAK, P_D0, P_D1, P_SETUP};
    vecs[0] = '{1'b0, 1'b1, 4'd0,    1'b0, 7'd0,  2'd0, E(1'b0, 4'd0, 5'b01000), 10'd0};
    vecs[1] = '{1'b1, 1'b1, P_IN,    1'b1, 7'd8,  2'd0, E(1'b0, 4'd0, 5'b01000), 10'd0};
    vecs[2] = '{1'b1, 1'b0, P_ACK,   1'b0, 7'd0,  2'd0, E(1'b0, 4'd0, 5'b00001), 10'd0};
    vecs[3] = '{1'b1, 1'b0, P_D1,    1'b0, 7'd0,  2'd0, E(1'b0, 4'd0, 5'b00001), 10'd0};
    vecs[4] = '{1'b1, 1'b0, P_SETUP, 1'b0, 7'd0,  2'd0, E(1'b0, 4'd0, 5'b00001), 10'd0};
    vecs[5] = '{1'b1, 1'b0, P_IN,    1'b0, 7'd8,  2'd1, E(1'b1, P_NAK, 5'b00000), E(1'b0, 4'd0, 5'b00000)};
    vecs[6] = '{1'b1, 1'b0, P_IN,    1'b1, 7'd0,  2'd1, E(1'b1, P_NAK, 5'b00000), E(1'b0, 4'd0, 5'b00000)};
    vecs[7] = '{1'b1, 1'b0, P_IN,    1'b1, 7'd64, 2'd2, E(1'b1, P_D0, 5'b10000),  E(1'b0, 4'd0, 5'b00001)};
    vecs[8] = '{1'b1, 1'b0, P_OUT,   1'b0, 7'd0,  2'd3, E(1'b0, 4'd0, 5'b00000),  E(1'b0, 4'd0, 5'b01000)};
    vecs[9] = '{1'b1, 1'b0, P_IN,    1'b1, 7'd1,  2'd2, E(1'b1, P_D0, 5'b10000),  E(1'b0, 4'd0, 5'b00001)};

    n_rst = 1'b0;
    idle_inputs();
    bus.rx_packet        = 4'd0;
    bus.data_request     = 1'b0;
    bus.buffer_occupancy = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", E(1'b0, 4'd0, 5'b00000), 1'b1);
    n_rst = 1'b1;
    tick();
    check("post_reset_idle", E(1'b0, 4'd0, 5'b00000), 1'b1);
    $display("txn reset checked");

    for (int i = 0; i < 10; i++) begin
      bus.rx_data_ready    = vecs[i].rdy;
      bus.rx_error         = vecs[i].err;
      bus.rx_packet        = vecs[i].pid;
      bus.data_request     = vecs[i].dr;
      bus.buffer_occupancy = vecs[i].occ;
      tick();
      check($sformatf("vec%0d", i), vecs[i].want, vecs[i].want[9]);
      if (vecs[i].rec != 2'd0) begin
        case (vecs[i].rec)
          2'd1:    bus.tx_done  = 1'b1;
          2'd2:    bus.tx_error = 1'b1;
          default: bus.rx_error = 1'b1;
        endcase
        tick();
        check($sformatf("vec%0d_recover", i), vecs[i].rec_want, 1'b0);
      end
      $display("txn vector %0d pid=%b applied", i, vecs[i].pid);
    end

    // OUT data toggling: new DATA0, duplicate DATA0, new DATA1.
    send_pid(P_OUT);
    send_pid(P_D0);
    check("out_d0_new", E(1'b1, P_ACK, 5'b00100), 1'b1);
    tick();
    check("out_ack_held", E(1'b0, P_ACK, 5'b00000), 1'b1);
    pulse_tx_done();
    check("out_ack_done", E(1'b0, 4'd0, 5'b00000), 1'b0);
    send_pid(P_OUT);
    send_pid(P_D0);
    check("out_d0_dup", E(1'b1, P_ACK, 5'b01000), 1'b1);
    pulse_tx_done();
    send_pid(P_OUT);
    send_pid(P_D1);
    check("out_d1_new", E(1'b1, P_ACK, 5'b00100), 1'b1);
    pulse_tx_done();
    $display("txn OUT toggle sequence");

    // IN: NAK without data, then DATA0 acknowledged by host.
    bus.data_request     = 1'b0;
    bus.buffer_occupancy = 7'd8;
    send_pid(P_IN);
    check("in_nak", E(1'b1, P_NAK, 5'b00000), 1'b1);
    pulse_tx_done();
    check("in_nak_done", E(1'b0, 4'd0, 5'b00000), 1'b0);
    bus.data_request = 1'b1;
    send_pid(P_IN);
    check("in_data0", E(1'b1, P_D0, 5'b10000), 1'b1);
    pulse_tx_done();
    check("in_wait_ack", E(1'b0, 4'd0, 5'b10000), 1'b0);
    send_pid(P_ACK);
    check("in_host_ack", E(1'b0, 4'd0, 5'b01010), 1'b0);
    $display("txn IN NAK then DATA0/ACK");

    // ACK timeout: abandon after 96 quiet cycles, then resend DATA1.
    send_pid(P_IN);
    check("in_data1", E(1'b1, P_D1, 5'b10000), 1'b1);
    pulse_tx_done();
    wait_pe(200, 0, at);
    check_val("ack_timeout_cycles", at, 96);
    check("ack_timeout_out", E(1'b0, 4'd0, 5'b00001), 1'b0);
    send_pid(P_IN);
    check("in_resend_data1", E(1'b1, P_D1, 5'b10000), 1'b1);
    pulse_tx_done();
    send_pid(P_ACK);
    check("in_resend_ack", E(1'b0, 4'd0, 5'b01010), 1'b0);
    $display("txn IN ACK timeout and resend");

    // DATA timeout with the timer frozen while the bus is busy.
    send_pid(P_OUT);
    wait_pe(300, 20, at);
    check_val("data_timeout_cycles", at, 116);
    check("data_timeout_out", E(1'b0, 4'd0, 5'b00001), 1'b0);
    $display("txn OUT DATA timeout");

    // rx_error beats rx_data_ready in WAIT_DATA.
    send_pid(P_OUT);
    bus.rx_error      = 1'b1;
    bus.rx_packet     = P_D0;
    bus.rx_data_ready = 1'b1;
    tick();
    check("rxerr_priority", E(1'b0, 4'd0, 5'b01000), 1'b0);
    bus.data_request = 1'b0;
    send_pid(P_IN);
    check("rxerr_back_idle", E(1'b1, P_NAK, 5'b00000), 1'b1);
    // tx_error beats tx_done.
    bus.tx_done  = 1'b1;
    bus.tx_error = 1'b1;
    tick();
    check("txerr_priority", E(1'b0, 4'd0, 5'b00001), 1'b0);
    send_pid(P_OUT);
    send_pid(P_IN);
    check("wait_data_bad_pid", E(1'b0, 4'd0, 5'b01001), 1'b0);
    bus.data_request = 1'b1;
    send_pid(P_IN);
    check("in_data0_b", E(1'b1, P_D0, 5'b10000), 1'b1);
    pulse_tx_done();
    bus.rx_error = 1'b1;
    tick();
    check("wait_ack_rxerr", E(1'b0, 4'd0, 5'b00001), 1'b0);
    send_pid(P_IN);
    check("in_data0_again", E(1'b1, P_D0, 5'b10000), 1'b1);
    pulse_tx_done();
    send_pid(P_ACK);
    check("in_data0_acked", E(1'b0, 4'd0, 5'b01010), 1'b0);
    $display("txn priority and error sequences");

    // Reset while waiting for the host ACK.
    send_pid(P_OUT);
    send_pid(P_D0);
    check("pre_reset_out", E(1'b1, P_ACK, 5'b00100), 1'b1);
    pulse_tx_done();
    send_pid(P_IN);
    check("pre_reset_in", E(1'b1, P_D1, 5'b10000), 1'b1);
    pulse_tx_done();
    #2;
    n_rst = 1'b0;
    #1;
    check("reset_async", E(1'b0, 4'd0, 5'b00000), 1'b1);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    send_pid(P_OUT);
    send_pid(P_D0);
    check("post_reset_rx_tog", E(1'b1, P_ACK, 5'b00100), 1'b1);
    pulse_tx_done();
    send_pid(P_IN);
    check("post_reset_tx_tog", E(1'b1, P_D0, 5'b10000), 1'b1);
    bus.tx_error = 1'b1;
    tick();
    check("post_reset_txerr", E(1'b0, 4'd0, 5'b00001), 1'b0);
    $display("txn reset during WAIT_ACK");

    m_rx_tog = 1'b1;
    m_tx_tog = 1'b0;
    for (int t = 0; t < 250; t++) rand_txn(t);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
